// File: rtl/active_devil_sweep_scheduler.sv
// active_devil_sweep_scheduler: steps the active-path FSM across an address window, one cache line per request
// Optional reply watchdog: define SWEEP_WDOG_EN to abandon a line after WDOG_CYCLES without a reply.
module active_devil_sweep_scheduler #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int LINE_BYTES         = 64,
    parameter int WDOG_CYCLES        = 4096
) (
    input  logic                          ace_aclk,
    input  logic                          ace_areset,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [C_ACE_ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_addr_size,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_delay,
    input  logic                          i_path_busy,
    input  logic                          i_path_reply,
    output logic                          o_trigger,
    output logic [C_ACE_ADDR_WIDTH-1:0]   o_line_addr,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_aborted,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_line_count
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_ACE_ADDR_WIDTH;
    localparam int LB = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic [DW:0]   r_remaining, w_lines;
    logic [DW-1:0] r_delay, r_gap, r_count;
    logic          r_aborted, r_abort_pend;
    logic          w_trigger, w_accept, w_reply, w_set_abort, w_timeout, w_end_abort;

    // one extra bit so a size near 2^DW rounds up without wrapping
    assign w_lines     = ({1'b0, i_addr_size} + (DW+1)'(LINE_BYTES - 1)) >> LB;
    assign w_accept    = (r_state == S_IDLE || r_state == S_DONE) && i_start;
    assign w_reply     = r_state == S_WAIT && i_path_reply;
    assign w_end_abort = r_abort_pend || i_abort;

`ifdef SWEEP_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] r_wdog;
    // cycles spent waiting on the current line's reply
    always_ff @(posedge ace_aclk) begin
        if (ace_areset || w_trigger) r_wdog <= '0;
        else if (r_state == S_WAIT) r_wdog <= r_wdog + WW'(1);
    end
    assign w_timeout = r_state == S_WAIT && !i_path_reply && r_wdog == WW'(WDOG_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge ace_aclk) begin
        if (ace_areset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // next-state, trigger strobe and abort-end decision
    always_comb begin
        w_next      = r_state;
        w_trigger   = 1'b0;
        w_set_abort = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (i_start) w_next = (w_lines == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                w_trigger   = !i_abort && !i_path_busy;
                w_set_abort = i_abort;
                w_next      = i_abort ? S_DONE : (i_path_busy ? S_ISSUE : S_WAIT);
            end
            S_WAIT: begin
                w_set_abort = (i_path_reply && w_end_abort) || w_timeout;
                w_next      = ((i_path_reply && (r_remaining == (DW+1)'(1) || w_end_abort)) || w_timeout) ? S_DONE :
                              i_path_reply ? ((r_delay == '0) ? S_ISSUE : S_GAP) : S_WAIT;
            end
            S_GAP: begin
                w_set_abort = i_abort;
                w_next      = i_abort ? S_DONE : ((r_gap == '0) ? S_ISSUE : S_GAP);
            end
            default: w_next = S_IDLE;
        endcase
    end

    // window latch on start, per-reply advance, abort and gap bookkeeping
    always_ff @(posedge ace_aclk) begin
        if (ace_areset) begin
            r_addr       <= '0;
            r_remaining  <= '0;
            r_delay      <= '0;
            r_gap        <= '0;
            r_count      <= '0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr       <= i_base_addr & ~AW'(LINE_BYTES - 1);
                r_remaining  <= w_lines;
                r_delay      <= i_delay;
                r_count      <= '0;
                r_aborted    <= 1'b0;
                r_abort_pend <= 1'b0;
            end else if (w_reply) begin
                r_addr      <= r_addr + AW'(LINE_BYTES);
                r_remaining <= r_remaining - (DW+1)'(1);
                r_count     <= r_count + DW'(1);
            end
            if (w_set_abort) r_aborted <= 1'b1;
            if (r_state == S_WAIT && i_abort) r_abort_pend <= 1'b1;
            r_gap <= (r_state == S_GAP) ? r_gap - DW'(1) : r_delay - DW'(1);
        end
    end

    assign o_trigger    = w_trigger;
    assign o_line_addr  = r_addr;
    assign o_busy       = r_state == S_ISSUE || r_state == S_WAIT || r_state == S_GAP;
    assign o_done       = r_state == S_DONE;
    assign o_aborted    = r_aborted;
    assign o_line_count = r_count;
endmodule
